// File: rtl/ctr_burst_seq_pkg.sv
// rtl/ctr_burst_seq_pkg.sv - shared state encoding and width defaults for the burst sequencer
package ctr_burst_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LEN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_pattern_ctr.sv
// rtl/seq_pattern_ctr.sv - free-running test-pattern up-counter advanced by FIFO writes
module seq_pattern_ctr
    import ctr_burst_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Advance once per accepted write; wraps naturally at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ctr_burst_seq.sv
// rtl/ctr_burst_seq.sv - burst sequencer writing gap-shaped counter bursts into the host FIFO
module ctr_burst_seq
    import ctr_burst_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [LEN_W-1:0] gap_len,
    input  logic [LEN_W-1:0] num_bursts,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_din,
    output logic             busy,
    output logic             done,
    output logic [31:0]      words_sent
);

    seq_state_t       r_state;
    logic [LEN_W-1:0] r_burst_len;
    logic [LEN_W-1:0] r_gap_len;
    logic [LEN_W-1:0] r_num_bursts;
    logic [LEN_W-1:0] r_beat;
    logic [LEN_W-1:0] r_gap_cnt;
    logic [LEN_W-1:0] r_burst_cnt;
    logic [31:0]      r_words_sent;

    logic             w_wr_en;
    logic             w_last_beat;
    logic             w_last_gap;
    logic [LEN_W-1:0] w_burst_cnt_nxt;
    logic             w_run_complete;

    // Write strobe is the only output allowed to follow inputs combinationally.
    assign w_wr_en         = (r_state == ST_BURST) && !fifo_full && !stop;
    assign w_last_beat     = (r_beat == r_burst_len - 1'b1);
    assign w_last_gap      = (r_gap_cnt == r_gap_len - 1'b1);
    assign w_burst_cnt_nxt = r_burst_cnt + 1'b1;
    assign w_run_complete  = (r_num_bursts != '0) && (w_burst_cnt_nxt == r_num_bursts);

    seq_pattern_ctr #(
        .WIDTH(WIDTH)
    ) u_pat (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (w_wr_en),
        .o_count (fifo_din)
    );

    // Run sequencing: accept config in IDLE, count beats/gaps/bursts, abort on stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_burst_len  <= '0;
            r_gap_len    <= '0;
            r_num_bursts <= '0;
            r_beat       <= '0;
            r_gap_cnt    <= '0;
            r_burst_cnt  <= '0;
            r_words_sent <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_burst_len  <= burst_len;
                        r_gap_len    <= gap_len;
                        r_num_bursts <= num_bursts;
                        r_beat       <= '0;
                        r_gap_cnt    <= '0;
                        r_burst_cnt  <= '0;
                        r_words_sent <= '0;
                        r_state      <= (burst_len == '0) ? ST_DONE : ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (stop) begin
                        r_state <= ST_DONE;
                    end else if (w_wr_en) begin
                        r_words_sent <= r_words_sent + 32'd1;
                        if (w_last_beat) begin
                            r_beat      <= '0;
                            r_burst_cnt <= w_burst_cnt_nxt;
                            if (w_run_complete) begin
                                r_state <= ST_DONE;
                            end else if (r_gap_len != '0) begin
                                r_gap_cnt <= '0;
                                r_state   <= ST_GAP;
                            end
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        r_state <= ST_DONE;
                    end else if (w_last_gap) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_BURST;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_wr_en = w_wr_en;
    assign busy       = (r_state == ST_BURST) || (r_state == ST_GAP);
    assign done       = (r_state == ST_DONE);
    assign words_sent = r_words_sent;

endmodule

// File: tb/tb_ctr_burst_seq.sv
// tb/tb_ctr_burst_seq.sv - directed self-checking bench for ctr_burst_seq
module tb_ctr_burst_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] burst_len;
    logic [15:0] gap_len;
    logic [15:0] num_bursts;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_din;
    logic        busy;
    logic        done;
    logic [31:0] words_sent;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          done_cnt = 0;
    int          bad_wr  = 0;
    logic [31:0] q_dat[$];
    int          q_cyc[$];

    ctr_burst_seq u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .burst_len  (burst_len),
        .gap_len    (gap_len),
        .num_bursts (num_bursts),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            q_dat.push_back(fifo_din);
            q_cyc.push_back(cyc);
            if (fifo_full) bad_wr++;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        q_dat.delete();
        q_cyc.delete();
        done_cnt = 0;
        bad_wr   = 0;
    endtask

    task automatic start_run(input logic [15:0] bl, input logic [15:0] gl, input logic [15:0] nb);
        @(posedge clk); #1;
        burst_len  = bl;
        gap_len    = gl;
        num_bursts = nb;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) break;
        end
        if (i == max_cyc) chk({tag, " done timeout"}, 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; fifo_full = 1'b0;
        burst_len = '0; gap_len = '0; num_bursts = '0;
        repeat (2) @(negedge clk);
        chk("rst wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst din", fifo_din, 32'd0);
        chk("rst words", words_sent, 32'd0);
        rst_n = 1'b1;

        // 3 bursts of 4 separated by 2 idle cycles
        clear_log();
        start_run(16'd4, 16'd2, 16'd3);
        wait_done("t1", 100);
        chk("t1 count", q_dat.size(), 32'd12);
        for (int i = 0; i < 12 && i < q_dat.size(); i++)
            chk($sformatf("t1 dat%0d", i), q_dat[i], 32'(i));
        for (int i = 1; i < 12 && i < q_cyc.size(); i++)
            chk($sformatf("t1 spacing%0d", i), 32'(q_cyc[i] - q_cyc[i-1]), (i % 4 == 0) ? 32'd3 : 32'd1);
        chk("t1 done pulses", done_cnt, 32'd1);
        chk("t1 words", words_sent, 32'd12);
        chk("t1 busy", {31'd0, busy}, 32'd0);

        // backpressure mid-burst
        do_reset();
        clear_log();
        start_run(16'd4, 16'd2, 16'd3);
        @(posedge clk); #1;
        fifo_full = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fifo_full = 1'b0;
        wait_done("t2", 100);
        chk("t2 count", q_dat.size(), 32'd12);
        for (int i = 0; i < 12 && i < q_dat.size(); i++)
            chk($sformatf("t2 dat%0d", i), q_dat[i], 32'(i));
        chk("t2 write while full", bad_wr, 32'd0);
        chk("t2 words", words_sent, 32'd12);

        // unlimited back-to-back bursts aborted by stop after 17 writes
        do_reset();
        clear_log();
        start_run(16'd5, 16'd0, 16'd0);
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                if (q_dat.size() >= 17) break;
                @(posedge clk); #1;
            end
            if (k == 100) chk("t3 write timeout", 32'd0, 32'd1);
        end
        stop = 1'b1;
        #1;
        chk("t3 wr in stop cycle", {31'd0, fifo_wr_en}, 32'd0);
        @(negedge clk); #1;
        @(posedge clk); #1;
        chk("t3 done after stop", {31'd0, done}, 32'd1);
        stop = 1'b0;
        @(posedge clk); #1;
        chk("t3 idle after done", {31'd0, busy | done}, 32'd0);
        chk("t3 count", q_dat.size(), 32'd17);
        if (q_dat.size() == 17) begin
            chk("t3 last dat", q_dat[16], 32'd16);
            chk("t3 continuous", 32'(q_cyc[16] - q_cyc[0]), 32'd16);
        end
        chk("t3 words", words_sent, 32'd17);

        // empty run
        clear_log();
        start_run(16'd0, 16'd3, 16'd2);
        chk("t4 done", {31'd0, done}, 32'd1);
        chk("t4 busy", {31'd0, busy}, 32'd0);
        wait_done("t4", 10);
        chk("t4 no writes", q_dat.size(), 32'd0);
        chk("t4 words", words_sent, 32'd0);

        // start and new config during BURST must be ignored
        clear_log();
        start_run(16'd4, 16'd2, 16'd2);
        @(posedge clk); #1;
        burst_len = 16'd1; gap_len = 16'd0; num_bursts = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t4b", 100);
        chk("t4b count", q_dat.size(), 32'd8);
        if (q_dat.size() == 8) begin
            chk("t4b first", q_dat[0], 32'd17);
            chk("t4b last", q_dat[7], 32'd24);
        end
        chk("t4b words", words_sent, 32'd8);

        // pattern counter wrap
        do_reset();
        clear_log();
        @(negedge clk);
        force u_dut.u_pat.r_count = 32'hFFFF_FFFE;
        #1;
        release u_dut.u_pat.r_count;
        #1;
        chk("t5 preload", fifo_din, 32'hFFFF_FFFE);
        start_run(16'd4, 16'd0, 16'd1);
        wait_done("t5", 50);
        chk("t5 count", q_dat.size(), 32'd4);
        if (q_dat.size() == 4) begin
            chk("t5 dat0", q_dat[0], 32'hFFFF_FFFE);
            chk("t5 dat1", q_dat[1], 32'hFFFF_FFFF);
            chk("t5 dat2", q_dat[2], 32'h0000_0000);
            chk("t5 dat3", q_dat[3], 32'h0000_0001);
        end

        // asynchronous reset during GAP
        clear_log();
        start_run(16'd4, 16'd3, 16'd2);
        begin
            int k;
            for (k = 0; k < 50; k++) begin
                if (q_dat.size() >= 4) break;
                @(posedge clk); #1;
            end
            if (k == 50) chk("t6 write timeout", 32'd0, 32'd1);
        end
        chk("t6 in gap busy", {31'd0, busy}, 32'd1);
        chk("t6 in gap wr_en", {31'd0, fifo_wr_en}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6 rst wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("t6 rst busy", {31'd0, busy}, 32'd0);
        chk("t6 rst done", {31'd0, done}, 32'd0);
        chk("t6 rst din", fifo_din, 32'd0);
        chk("t6 rst words", words_sent, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        start_run(16'd2, 16'd0, 16'd1);
        wait_done("t6b", 50);
        chk("t6b count", q_dat.size(), 32'd2);
        if (q_dat.size() == 2) begin
            chk("t6b dat0", q_dat[0], 32'd0);
            chk("t6b dat1", q_dat[1], 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
